uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
- Frame format set at elaboration: data bits, parity mode, stop bits.
- Internal input FIFO of configurable depth.
- Adds back-to-back framing with no idle gap, a line-break generator and a busy flag.
- Sits between on-chip byte producers (valid/ready) and the board TX pin.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_cfg_if.sv | 14 +
 rtl/uart_tx_cfg_fifo.sv | 62 ++++++
 rtl/uart_tx_cfg.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

    // Line bits per frame: start + payload + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake, break request and line/status signals of the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 break_req;
    logic                 busy;
    logic                 out;

    modport master (output in_data, in_valid, break_req, input in_ready, busy, out);
    modport slave  (input in_data, in_valid, break_req, output in_ready, busy, out);
endinterface

// File: rtl/uart_tx_cfg_fifo.sv
// First-word-fall-through FIFO; a word pushed at one edge is visible on the pop side from the next cycle.
module uart_tx_cfg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             pop_valid_o,
    input  logic             pop_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO depth must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    // A full FIFO refuses the push even when the same edge pops.
    assign push_ready_o = rst_n && (count_q != FULL);
    assign pop_valid_o  = (count_q != '0);
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && pop_valid_o;
    assign pop_data_o   = mem_q[rd_ptr_q];

    // NOTE: every variable gets its default before any branch, so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: storage is not reset; clearing the pointers and count is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: elaboration-time frame format, input FIFO, back-to-back frames, line break.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_cfg_if.slave bus
);
    localparam int BIT_CYCLES   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int FRAME_CYCLES = frame_bits(DATA_BITS, PARITY, STOP_BITS) * BIT_CYCLES;
    localparam int BRK_W        = $clog2(FRAME_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [BRK_W-1:0] BRK_LAST  = BRK_W'(FRAME_CYCLES - 1);
    localparam parity_e          PAR_MODE  = parity_e'(PARITY[1:0]);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2)
        || (PARITY < 0) || (PARITY > 2)) begin : g_bad_format
        $error("unsupported frame format");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BRK_W-1:0]     brk_q, brk_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_valid;
    logic                 load;
    logic                 bit_done;

    uart_tx_cfg_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) in_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_data_i (bus.in_data),
        .push_valid_i(bus.in_valid),
        .push_ready_o(bus.in_ready),
        .pop_data_o  (fifo_data),
        .pop_valid_o (fifo_valid),
        .pop_i       (load)
    );

    assign bit_done = (cnt_q == CNT_LAST);
    assign bus.busy = (state_q != IDLE);
    assign bus.out  = out_q;

    // The line level is computed from the current state and registered, so the pin lags the state by one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        brk_d   = brk_q;
        out_d   = 1'b1;
        load    = 1'b0;
        cnt_d   = (state_q == IDLE || state_q == BREAK || bit_done) ? '0 : cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (bus.break_req) begin
                    state_d = BREAK;
                    brk_d   = '0;
                end else if (fifo_valid) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                out_d = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                out_d = shift_q[0];
                if (bit_done) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                out_d = par_q;
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                // Last stop cycle is the only mid-stream point where break or the next word is considered.
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        if (bus.break_req) begin
                            state_d = BREAK;
                            brk_d   = '0;
                        end else if (fifo_valid) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                out_d = 1'b0;
                if (brk_q != BRK_LAST) begin
                    brk_d = brk_q + 1'b1;
                end else if (!bus.break_req) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        if (load) begin
            shift_d = fifo_data;
            par_d   = (PAR_MODE == PAR_ODD) ? ~^fifo_data : ^fifo_data;
        end else if (state_q == DATA && bit_done) begin
            shift_d = shift_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            brk_q   <= '0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            brk_q   <= brk_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8N1 and a 7O2 instance, line traces decoded by a behavioural UART receiver.
module tb_uart_tx_cfg;
    localparam int BC = 4;
    localparam int K_FRAME = 0, K_ERR = 1, K_BREAK = 2;

    typedef struct {
        int kind;
        int value;
        int start;
        int len;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic tr_a[$], bz_a[$], tr_b[$], bz_b[$];

    uart_tx_cfg_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_cfg_if #(.DATA_BITS(7)) bus_b ();

    uart_tx_cfg #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    uart_tx_cfg #(
        .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    // Line and busy are captured once per cycle, away from the rising edge.
    always @(negedge clk) begin
        tr_a.push_back(bus_a.out);
        bz_a.push_back(bus_a.busy);
        tr_b.push_back(bus_b.out);
        bz_b.push_back(bus_b.busy);
    end

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int k);
        int n;
        n = k - tr_a.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [7:0] d, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        bus_a.in_data  = d;
        bus_a.in_valid = 1'b1;
        while (!acc && waited < 200) begin
            acc = (bus_a.in_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        bus_a.in_valid = 1'b0;
        check("push_a_accepted", 32'(acc), 1);
    endtask

    task automatic push_b(input logic [6:0] d, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        bus_b.in_data  = d;
        bus_b.in_valid = 1'b1;
        while (!acc && waited < 200) begin
            acc = (bus_b.in_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        bus_b.in_valid = 1'b0;
        check("push_b_accepted", 32'(acc), 1);
    endtask

    // Expected level of line bit k of a frame carrying val.
    function automatic int frame_bit(input int k, input int val, input int db, input int par);
        int ones;
        ones = $countones(val);
        if (k == 0) return 0;
        if (k <= db) return (val >> (k - 1)) & 1;
        if (par != 0 && k == db + 1) return (par == 1) ? ones % 2 : 1 - ones % 2;
        return 1;
    endfunction

    function automatic int wave_errors(input logic tr[$], input int start, input int val,
                                       input int db, input int par, input int sb);
        int nb, errs;
        nb = 1 + db + ((par != 0) ? 1 : 0) + sb;
        errs = 0;
        for (int k = 0; k < nb * BC; k++)
            if (tr[start + k] !== 1'(frame_bit(k / BC, val, db, par))) errs++;
        return errs;
    endfunction

    function automatic int count_high(input logic q[$], input int from, input int n);
        int c;
        c = 0;
        for (int k = from; k < from + n; k++) if (q[k] === 1'b1) c++;
        return c;
    endfunction

    // Receiver: every bit must hold BIT_CYCLES samples; an all-low frame with low stop is a break.
    function automatic void decode(input logic tr[$], input int from, input int db, input int par,
                                   input int sb, output ev_t evs[$]);
        int   nb, i, j, val, pbit;
        logic bv[16];
        bit   steady, allz, ok;
        nb = 1 + db + ((par != 0) ? 1 : 0) + sb;
        evs = {};
        i = from;
        while (i < tr.size()) begin
            if (tr[i] !== 1'b0) begin
                i++;
                continue;
            end
            if (i + nb * BC > tr.size()) break;
            steady = 1'b1;
            allz = 1'b1;
            for (int k = 0; k < nb; k++) begin
                bv[k] = tr[i + k * BC];
                for (int c = 1; c < BC; c++) if (tr[i + k * BC + c] !== bv[k]) steady = 1'b0;
                if (bv[k] !== 1'b0) allz = 1'b0;
            end
            val = 0;
            for (int k = 0; k < db; k++) if (bv[1 + k] === 1'b1) val |= (1 << k);
            ok = steady;
            pbit = (bv[1 + db] === 1'b1) ? 1 : 0;
            if (par == 1 && pbit != $countones(val) % 2) ok = 1'b0;
            if (par == 2 && pbit != 1 - $countones(val) % 2) ok = 1'b0;
            for (int k = nb - sb; k < nb; k++) if (bv[k] !== 1'b1) ok = 1'b0;
            if (ok) begin
                evs.push_back('{K_FRAME, val, i, nb * BC});
                i += nb * BC;
            end else if (allz) begin
                j = i;
                while (j < tr.size() && tr[j] === 1'b0) j++;
                evs.push_back('{K_BREAK, 0, i, j - i});
                i = j;
            end else begin
                evs.push_back('{K_ERR, val, i, nb * BC});
                i += nb * BC;
            end
        end
    endfunction

    initial begin : stim
        int         m, s, k, w, tot, nacc, streak, gaps;
        bit         rdy;
        ev_t        evs[$];
        logic [7:0] words[10];
        logic [7:0] w1, w2;
        logic [6:0] wb[5];

        rst_n = 1'b0;
        bus_a.in_valid = 1'b0;  bus_a.in_data = '0;  bus_a.break_req = 1'b0;
        bus_b.in_valid = 1'b0;  bus_b.in_data = '0;  bus_b.break_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_a", 32'(bus_a.out), 1);
        check("reset_busy_a", 32'(bus_a.busy), 0);
        check("reset_ready_a", 32'(bus_a.in_ready), 0);
        check("reset_out_b", 32'(bus_b.out), 1);
        rst_n = 1'b1;
        wait_until(tr_a.size() + 2);
        check("ready_after_reset_a", 32'(bus_a.in_ready), 1);

        // 8N1, single 0xA5
        m = tr_a.size();
        push_a(8'hA5, w);
        wait_until(m + 50);
        decode(tr_a, m, 8, 0, 1, evs);
        check("a5_frames", evs.size(), 1);
        if (evs.size() > 0) begin
            check("a5_kind", evs[0].kind, K_FRAME);
            check("a5_value", evs[0].value, 8'hA5);
            check("a5_start", evs[0].start, m + 3);
        end
        check("a5_wave_errors", wave_errors(tr_a, m + 3, 8'hA5, 8, 0, 1), 0);
        check("a5_line_before", 32'(tr_a[m + 2]), 1);
        check("a5_busy_span", count_high(bz_a, m + 2, 40), 40);
        check("a5_busy_end", 32'(bz_a[m + 42]), 0);

        // three contiguous frames with in_ready staying high
        m = tr_a.size();
        tot = 0;
        push_a(8'h00, w);  tot += w;
        push_a(8'hFF, w);  tot += w;
        push_a(8'h55, w);  tot += w;
        check("b2b_ready_cycles", tot, 3);
        wait_until(m + 3 + 120 + 6);
        decode(tr_a, m, 8, 0, 1, evs);
        check("b2b_frames", evs.size(), 3);
        if (evs.size() == 3) begin
            check("b2b_v0", evs[0].value, 8'h00);
            check("b2b_v1", evs[1].value, 8'hFF);
            check("b2b_v2", evs[2].value, 8'h55);
            check("b2b_start0", evs[0].start, m + 3);
            check("b2b_gap01", evs[1].start - evs[0].start, 40);
            check("b2b_gap12", evs[2].start - evs[1].start, 40);
        end

        // burst of random words with in_valid held high
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom_range(0, 255));
        m = tr_a.size();
        nacc = 0;
        streak = -1;
        bus_a.in_data = words[0];
        bus_a.in_valid = 1'b1;
        for (int n = 0; n < 600 && nacc < 10; n++) begin
            rdy = (bus_a.in_ready === 1'b1);
            if (!rdy && streak < 0) streak = nacc;
            @(posedge clk);
            #1;
            if (rdy) begin
                nacc++;
                if (nacc < 10) bus_a.in_data = words[nacc];
            end
        end
        bus_a.in_valid = 1'b0;
        check("burst_ready_streak", streak, 5);
        check("burst_accepted", nacc, 10);
        wait_until(m + 3 + 400 + 6);
        decode(tr_a, m, 8, 0, 1, evs);
        check("burst_frames", evs.size(), 10);
        gaps = 0;
        for (int i = 0; i < evs.size() && i < 10; i++) begin
            check("burst_value", evs[i].value, 32'(words[i]));
            if (i > 0 && evs[i].start - evs[i - 1].start != 40) gaps++;
        end
        check("burst_gaps", gaps, 0);

        // break requested across the end of a frame
        w1 = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        m = tr_a.size();
        push_a(w1, w);
        push_a(w2, w);
        s = m + 3;
        wait_until(s + 36);
        bus_a.break_req = 1'b1;
        wait_until(s + 41);
        bus_a.break_req = 1'b0;
        wait_until(s + 84 + 46);
        decode(tr_a, m, 8, 0, 1, evs);
        check("brk_events", evs.size(), 3);
        if (evs.size() == 3) begin
            check("brk_w1", evs[0].value, 32'(w1));
            check("brk_w1_kind", evs[0].kind, K_FRAME);
            check("brk_kind", evs[1].kind, K_BREAK);
            check("brk_start", evs[1].start, s + 40);
            check("brk_min_len", 32'(evs[1].len >= 40), 1);
            check("brk_high_gap", evs[2].start - (evs[1].start + evs[1].len), 4);
            check("brk_w2", evs[2].value, 32'(w2));
        end

        // reset during DATA drops the frame and queued words
        m = tr_a.size();
        push_a(8'h5A, w);
        push_a(8'h11, w);
        push_a(8'h22, w);
        wait_until(m + 3 + 10);
        rst_n = 1'b0;
        #1;
        check("rst_ready_low", 32'(bus_a.in_ready), 0);
        k = tr_a.size();
        wait_until(k + 1);
        rst_n = 1'b1;
        wait_until(k + 2);
        check("rst_out_high", 32'(tr_a[k + 1]), 1);
        check("rst_busy_low", 32'(bz_a[k + 1]), 0);
        m = tr_a.size();
        push_a(8'h3C, w);
        wait_until(m + 3 + 130);
        decode(tr_a, m, 8, 0, 1, evs);
        check("rst_frames", evs.size(), 1);
        if (evs.size() > 0) begin
            check("rst_value", evs[0].value, 8'h3C);
            check("rst_start", evs[0].start, m + 3);
        end

        // 7 data bits, odd parity, 2 stop bits
        m = tr_b.size();
        push_b(7'h03, w);
        wait_until(m + 54);
        decode(tr_b, m, 7, 2, 2, evs);
        check("o72_frames", evs.size(), 1);
        if (evs.size() > 0) begin
            check("o72_value", evs[0].value, 7'h03);
            check("o72_start", evs[0].start, m + 3);
        end
        check("o72_wave_errors", wave_errors(tr_b, m + 3, 7'h03, 7, 2, 2), 0);
        check("o72_parity_bit", 32'(tr_b[m + 3 + 8 * BC + 1]), 1);
        check("o72_busy_span", count_high(bz_b, m + 2, 44), 44);
        check("o72_busy_end", 32'(bz_b[m + 46]), 0);

        m = tr_b.size();
        for (int i = 0; i < 5; i++) begin
            wb[i] = 7'($urandom_range(0, 127));
            push_b(wb[i], w);
        end
        wait_until(m + 3 + 5 * 44 + 8);
        decode(tr_b, m, 7, 2, 2, evs);
        check("o72_burst_frames", evs.size(), 5);
        gaps = 0;
        for (int i = 0; i < evs.size() && i < 5; i++) begin
            check("o72_burst_value", evs[i].value, 32'(wb[i]));
            if (i > 0 && evs[i].start - evs[i - 1].start != 44) gaps++;
        end
        check("o72_burst_gaps", gaps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
